cordic_fix2fp_pipe: RTL and testbench

- Downstream neighbour of the unrolled CORDIC cosine core.
- Consumes the core's signed Q1.20 `x` result and its level `done` flag, and emits an IEEE-754 single-precision result with a one-cycle valid pulse.
- Implemented as a 3-stage pipeline: absolute value, leading-one detect, normalise/pack.
- Replaces the combinational fixed-to-float path, taking it off the CORDIC critical path.

---
 rtl/cordic_pkg.sv | 18 +
 rtl/lzc_w21.sv | 20 ++
 rtl/cordic_fix2fp_pipe.sv | 116 +++++++++++
 tb/tb_cordic_fix2fp_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC fixed-to-float output path.
// Latency: none (declarations only). Backpressure: none.
// Fixed-point layout is signed Q1.20; float layout is IEEE-754 single.
package cordic_pkg;

    localparam int WL      = 21;
    localparam int FRAC    = 20;
    localparam int FP_BIAS = 127;

    typedef logic signed [WL-1:0] fix_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

endpackage

// File: rtl/lzc_w21.sv
// Leading-one index (0..20) and zero flag of a WL-bit magnitude.
// Latency: combinational. Backpressure: none.
// The highest set bit wins; pos is 0 when din is zero.
module lzc_w21
    import cordic_pkg::*;
(
    input  logic [WL-1:0] din,
    output logic [4:0]    pos,
    output logic          zero
);

    always_comb begin
        pos  = '0;
        zero = (din == '0);
        for (int i = 0; i < WL; i++) begin
            if (din[i]) pos = 5'(i);
        end
    end

endmodule

// File: rtl/cordic_fix2fp_pipe.sv
// Q1.20 CORDIC result to IEEE-754 single; optional CORDIC_FIX2FP_NEG_FLUSH_EN flushes negatives to +0.0.
// Latency: 3 cycles from the sampled in_done rising edge to the out_valid pulse.
// Backpressure: none; clk_en low freezes every stage, including a pending out_valid.
module cordic_fix2fp_pipe
    import cordic_pkg::*;
(
    input  logic          clock,
    input  logic          aclr,
    input  logic          clk_en,
    input  logic          in_done,
    input  logic [WL-1:0] in_data,
    output logic          out_valid,
    output logic [31:0]   out_data,
    output logic          busy
);

    logic          done_q;
    logic          accept;
    fix_t          in_fix;
    logic [WL:0]   in_ext;
    logic [WL:0]   in_mag;

    logic          s1_vld;
    logic          s1_sign;
    logic [WL:0]   s1_mag;

    logic [4:0]    lzc_pos;
    logic          lzc_zero;

    logic          s2_vld;
    logic          s2_sign;
    logic          s2_zero;
    logic [4:0]    s2_pos;
    logic [WL:0]   s2_mag;

    logic          flush;
    logic [4:0]    shamt;
    fp32_t         packed_res;

    assign accept = clk_en & in_done & ~done_q;
    assign in_fix = fix_t'(in_data);
    assign in_ext = {in_fix[WL-1], in_fix};
    // One extra bit so that -1.0 negates to a clean 2^20.
    assign in_mag = in_fix[WL-1] ? (~in_ext + 1'b1) : in_ext;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            done_q  <= 1'b0;
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_mag  <= '0;
        end else if (clk_en) begin
            done_q <= in_done;
            s1_vld <= accept;
            if (accept) begin
                s1_sign <= in_fix[WL-1];
                s1_mag  <= in_mag;
            end
        end
    end

    lzc_w21 u_lzc (
        .din  (s1_mag[WL-1:0]),
        .pos  (lzc_pos),
        .zero (lzc_zero)
    );

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            s2_vld  <= 1'b0;
            s2_sign <= 1'b0;
            s2_zero <= 1'b0;
            s2_pos  <= '0;
            s2_mag  <= '0;
        end else if (clk_en) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_sign <= s1_sign;
                s2_zero <= lzc_zero;
                s2_pos  <= lzc_pos;
                s2_mag  <= s1_mag;
            end
        end
    end

`ifdef CORDIC_FIX2FP_NEG_FLUSH_EN
    assign flush = s2_sign;
`else
    assign flush = 1'b0;
`endif

    assign shamt = 5'd23 - s2_pos;

    // Magnitude has at most 21 significant bits, so the shift is exact and no rounding applies.
    always_comb begin
        packed_res = '0;
        if (!s2_zero && !flush) begin
            packed_res.sign = s2_sign;
            packed_res.exp  = 8'(FP_BIAS - FRAC) + {3'b000, s2_pos};
            packed_res.man  = 23'({{(31 - WL){1'b0}}, s2_mag} << shamt);
        end
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            out_valid <= 1'b0;
            out_data  <= 32'h0;
        end else if (clk_en) begin
            out_valid <= s2_vld;
            if (s2_vld) out_data <= packed_res;
        end
    end

    assign busy = s1_vld | s2_vld | out_valid;

endmodule

// File: tb/tb_cordic_fix2fp_pipe.sv
// Self-checking bench for cordic_fix2fp_pipe against a real-valued conversion model.
module tb_cordic_fix2fp_pipe;

    logic        clock = 1'b0;
    logic        aclr;
    logic        clk_en;
    logic        in_done;
    logic [20:0] in_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        busy;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    bit          mon_en = 1'b0;
    logic [31:0] mon_exp;

    always #5 clock = ~clock;

    cordic_fix2fp_pipe dut (
        .clock     (clock),
        .aclr      (aclr),
        .clk_en    (clk_en),
        .in_done   (in_done),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Value = signed(d) * 2^-20, converted through a double and narrowed to single.
    function automatic logic [31:0] ref_fp(input logic [20:0] d);
        logic signed [20:0] s;
        real                r;
        logic [63:0]        b;
        logic [10:0]        e;
        s = d;
        r = $itor(s) / 1048576.0;
        if (r == 0.0) return 32'h0;
`ifdef CORDIC_FIX2FP_NEG_FLUSH_EN
        if (r < 0.0) return 32'h0;
`endif
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic pulse_and_wait(input logic [20:0] d, output logic [31:0] got,
                                  output int lat, output bit seen);
        in_data = d;
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            tick();
            lat++;
        end
        seen = out_valid;
        got  = out_data;
        tick();
    endtask

    always @(negedge clock) begin
        if (mon_en && out_valid) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sweep_extra: got %h with no expected value pending", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp) begin
                    n_bad++;
                    $display("FAIL sweep_data: got %h want %h", out_data, mon_exp);
                end
            end
        end
    end

    task automatic test_reset();
        aclr    = 1'b1;
        clk_en  = 1'b1;
        in_done = 1'b0;
        in_data = '0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_vec++;
        if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_data: got %h want 00000000", out_data); end
        n_vec++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        tick();
        tick();
        aclr = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic exp_v[4];
        logic exp_b[4];
        exp_v = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_b = '{1'b1, 1'b1, 1'b1, 1'b0};
        in_data = 21'h080000;
        in_done = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            in_done = 1'b0;
            n_vec++;
            if (out_valid !== exp_v[c]) begin
                n_bad++;
                $display("FAIL basic_valid_c%0d: got %b want %b", c + 1, out_valid, exp_v[c]);
            end
            n_vec++;
            if (busy !== exp_b[c]) begin
                n_bad++;
                $display("FAIL basic_busy_c%0d: got %b want %b", c + 1, busy, exp_b[c]);
            end
            if (c == 2) begin
                n_vec++;
                if (out_data !== 32'h3F000000) begin
                    n_bad++;
                    $display("FAIL basic_data: got %h want 3f000000", out_data);
                end
            end
        end
    endtask

    task automatic test_values();
        logic [20:0] vd[5];
        logic [31:0] ve[5];
        logic [31:0] got;
        int          lat;
        bit          seen;
        vd = '{21'h000001, 21'h000000, 21'h100000, 21'h180000, 21'h0FFFFF};
`ifdef CORDIC_FIX2FP_NEG_FLUSH_EN
        ve = '{32'h35800000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h3F7FFFF0};
`else
        ve = '{32'h35800000, 32'h00000000, 32'hBF800000, 32'hBF000000, 32'h3F7FFFF0};
`endif
        for (int i = 0; i < 5; i++) begin
            pulse_and_wait(vd[i], got, lat, seen);
            n_vec++;
            if (!seen || lat != 3) begin
                n_bad++;
                $display("FAIL values_latency[%h]: got seen=%0b lat=%0d want seen=1 lat=3", vd[i], seen, lat);
            end
            n_vec++;
            if (got !== ve[i]) begin
                n_bad++;
                $display("FAIL values_data[%h]: got %h want %h", vd[i], got, ve[i]);
            end
        end
    endtask

    task automatic test_level_hold();
        int          pulses = 0;
        logic [31:0] got = '0;
        in_data = 21'h0FFFFF;
        in_done = 1'b1;
        repeat (10) begin
            tick();
            if (out_valid) begin pulses++; got = out_data; end
        end
        in_done = 1'b0;
        repeat (4) begin
            tick();
            if (out_valid) begin pulses++; got = out_data; end
        end
        n_vec++;
        if (pulses != 1) begin n_bad++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
        n_vec++;
        if (got !== 32'h3F7FFFF0) begin n_bad++; $display("FAIL hold_data: got %h want 3f7ffff0", got); end
    endtask

    task automatic test_stall();
        int lat;
        bit early = 1'b0;
        in_data = 21'h040000;
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        tick();
        clk_en = 1'b0;
        repeat (5) begin
            tick();
            if (out_valid) early = 1'b1;
        end
        n_vec++;
        if (early || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_freeze: got early=%0b busy=%b want early=0 busy=1", early, busy);
        end
        clk_en = 1'b1;
        lat = 7;
        while (!out_valid && lat < 15) begin
            tick();
            lat++;
        end
        n_vec++;
        if (!out_valid || lat != 8) begin
            n_bad++;
            $display("FAIL stall_latency: got valid=%b lat=%0d want valid=1 lat=8", out_valid, lat);
        end
        n_vec++;
        if (out_data !== 32'h3E800000) begin n_bad++; $display("FAIL stall_data: got %h want 3e800000", out_data); end
        clk_en = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h3E800000) begin
            n_bad++;
            $display("FAIL stall_pending: got valid=%b data=%h want valid=1 data=3e800000", out_valid, out_data);
        end
        clk_en = 1'b1;
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_drop: got %b want 0", out_valid); end
    endtask

    task automatic test_abort();
        bit pulsed = 1'b0;
        in_data = 21'h080000;
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        aclr = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || out_data !== 32'h0) begin
            n_bad++;
            $display("FAIL abort_async: got busy=%b data=%h want busy=0 data=00000000", busy, out_data);
        end
        tick();
        aclr = 1'b0;
        repeat (6) begin
            tick();
            if (out_valid) pulsed = 1'b1;
        end
        n_vec++;
        if (pulsed || out_data !== 32'h0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_flush: got pulse=%0b data=%h busy=%b want 0/00000000/0", pulsed, out_data, busy);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] r;
        int          k;
        int          guard = 0;
        mon_en = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            r = $urandom;
            in_data = r[20:0];
            in_done = 1'b1;
            exp_q.push_back(ref_fp(r[20:0]));
            k = $urandom_range(1, 3);
            repeat (k) tick();
            in_done = 1'b0;
            tick();
        end
        while (exp_q.size() != 0 && guard < 20) begin
            tick();
            guard++;
        end
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL sweep_drain: got %0d outputs missing want 0", exp_q.size());
        end
        mon_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_level_hold();
        test_stall();
        test_abort();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
